// File: rtl/elbeth_load_store_unit.sv
// elbeth_load_store_unit: CPU-side initiator for one port of the dual-port data RAM.
// Turns byte/half/word load/store requests into a single RAM access, builds byte-lane
// enables, sign/zero-extends load data and stalls the pipeline while the access is in flight.
// Optional watchdog abort in WAIT: define ELBETH_LSU_TIMEOUT_EN.
module elbeth_load_store_unit #(
    parameter int unsigned AW             = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req_valid,
    input  logic          cpu_req_we,
    input  logic [31:0]   cpu_req_addr,
    input  logic [1:0]    cpu_req_size,
    input  logic          cpu_req_unsigned,
    input  logic [31:0]   cpu_req_wdata,
    output logic          cpu_stall,
    output logic          cpu_done,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_misaligned,
    output logic          cpu_timeout,
    output logic          mem_enable,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_data_out,
    output logic [3:0]    mem_rw,
    input  logic [31:0]   mem_data_in,
    input  logic          mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    lane_q, lane_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          we_q, we_d;
    logic [3:0]    rw_q, rw_d;
    logic [31:0]   dout_q, dout_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mis_q, mis_d;
    logic          tmo_q, tmo_d;

    logic          req_err;
    logic [3:0]    req_rw;
    logic [31:0]   req_dout;
    logic [31:0]   load_ext;

    // Upper byte-address bits beyond the RAM are ignored, so the address wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^cpu_req_addr[31:AW+2];

`ifdef ELBETH_LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Alignment check and store lane/data formatting for the incoming request
    always_comb begin
        req_err  = 1'b0;
        req_rw   = '0;
        req_dout = '0;
        case (cpu_req_size)
            SZ_BYTE: begin
                req_rw   = 4'b0001 << cpu_req_addr[1:0];
                req_dout = {4{cpu_req_wdata[7:0]}};
            end
            SZ_HALF: begin
                req_err  = cpu_req_addr[0];
                req_rw   = 4'b0011 << cpu_req_addr[1:0];
                req_dout = {2{cpu_req_wdata[15:0]}};
            end
            SZ_WORD: begin
                req_err  = |cpu_req_addr[1:0];
                req_rw   = 4'b1111;
                req_dout = cpu_req_wdata;
            end
            default: req_err = 1'b1;
        endcase
        if (!cpu_req_we) begin
            req_rw = '0;
        end
    end

    // Lane select and sign/zero extension of RAM read data
    always_comb begin
        logic [31:0] shifted;
        shifted  = mem_data_in >> {lane_q, 3'b000};
        load_ext = mem_data_in;
        case (size_q)
            SZ_BYTE: load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = mem_data_in;
        endcase
    end

    // Next-state logic; response registers are only non-zero for the RESP cycle
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        size_d  = size_q;
        uns_d   = uns_q;
        we_d    = we_q;
        rw_d    = rw_q;
        dout_d  = dout_q;
        rdata_d = '0;
        mis_d   = 1'b0;
        tmo_d   = 1'b0;
`ifdef ELBETH_LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    addr_d = cpu_req_addr[AW+1:2];
                    lane_d = cpu_req_addr[1:0];
                    size_d = cpu_req_size;
                    uns_d  = cpu_req_unsigned;
                    we_d   = cpu_req_we;
                    rw_d   = req_rw;
                    dout_d = req_dout;
                    if (req_err) begin
                        mis_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
`ifdef ELBETH_LSU_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    rdata_d = we_q ? '0 : load_ext;
                    state_d = S_RESP;
                end
`ifdef ELBETH_LSU_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            rw_q    <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            rw_q    <= rw_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef ELBETH_LSU_TIMEOUT_EN
    // Watchdog counter of WAIT cycles without mem_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // RAM port is driven only in ACCESS, so no write can leak out in any other state
    always_comb begin
        mem_enable   = (state_q == S_ACCESS);
        mem_addr     = mem_enable ? addr_q : '0;
        mem_rw       = mem_enable ? rw_q : '0;
        mem_data_out = mem_enable ? dout_q : '0;
    end

    // CPU-side outputs
    always_comb begin
        cpu_stall      = ((state_q == S_IDLE) & cpu_req_valid) |
                         (state_q == S_ACCESS) | (state_q == S_WAIT);
        cpu_done       = (state_q == S_RESP);
        cpu_rdata      = rdata_q;
        cpu_misaligned = mis_q;
        cpu_timeout    = tmo_q;
    end

endmodule

// File: tb/tb_elbeth_load_store_unit.sv
// Directed testbench for elbeth_load_store_unit with a small behavioural RAM.
// Build with ELBETH_LSU_TIMEOUT_EN defined to exercise the watchdog abort.
module tb_elbeth_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic [1:0]  cpu_req_size;
    logic        cpu_req_unsigned;
    logic [31:0] cpu_req_wdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_misaligned;
    logic        cpu_timeout;
    logic        mem_enable;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data_out;
    logic [3:0]  mem_rw;
    logic [31:0] mem_data_in;
    logic        mem_ready;

    elbeth_load_store_unit #(.AW(8), .TIMEOUT_CYCLES(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_req_valid    (cpu_req_valid),
        .cpu_req_we       (cpu_req_we),
        .cpu_req_addr     (cpu_req_addr),
        .cpu_req_size     (cpu_req_size),
        .cpu_req_unsigned (cpu_req_unsigned),
        .cpu_req_wdata    (cpu_req_wdata),
        .cpu_stall        (cpu_stall),
        .cpu_done         (cpu_done),
        .cpu_rdata        (cpu_rdata),
        .cpu_misaligned   (cpu_misaligned),
        .cpu_timeout      (cpu_timeout),
        .mem_enable       (mem_enable),
        .mem_addr         (mem_addr),
        .mem_data_out     (mem_data_out),
        .mem_rw           (mem_rw),
        .mem_data_in      (mem_data_in),
        .mem_ready        (mem_ready)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: samples enable/write at the edge, answers ready one cycle later
    // unless hold is set. Read bus carries junk when not ready.
    logic [31:0] ram [256];
    logic [31:0] rd_q;
    logic        pend;
    logic        hold;

    always @(posedge clk) begin
        if (mem_enable) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_rw[i]) ram[mem_addr][8*i +: 8] <= mem_data_out[8*i +: 8];
            end
            rd_q <= ram[mem_addr];
        end
        if (rst) pend <= 1'b0;
        else if (mem_enable) pend <= 1'b1;
        else if (mem_ready) pend <= 1'b0;
    end

    assign mem_ready   = pend & ~hold;
    assign mem_data_in = mem_ready ? rd_q : 32'h5A5A_5A5A;

    // Any write enable outside an enabled cycle is a spurious write
    int spur = 0;
    always @(negedge clk) begin
        if (!mem_enable && (mem_rw != 4'b0000)) spur++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Results of the most recent transaction
    logic [31:0] r_lat, r_rdata, r_en, r_addr, r_rw, r_dout;
    logic [31:0] r_mis, r_tmo, r_stall0, r_stall_resp, r_done_after, r_rdata_after;

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input int budget);
        cpu_req_we       = we;
        cpu_req_addr     = addr;
        cpu_req_size     = size;
        cpu_req_unsigned = uns;
        cpu_req_wdata    = wdata;
        cpu_req_valid    = 1'b1;
        r_lat = 32'd999; r_en = 0; r_addr = 0; r_rw = 0; r_dout = 0;
        r_rdata = 0; r_mis = 0; r_tmo = 0; r_stall_resp = 0;
        #1;
        r_stall0 = 32'(cpu_stall);
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (mem_enable) begin
                r_en++;
                r_addr = 32'(mem_addr);
                r_rw   = 32'(mem_rw);
                r_dout = mem_data_out;
            end
            if (cpu_done) begin
                r_lat        = c;
                r_rdata      = cpu_rdata;
                r_mis        = 32'(cpu_misaligned);
                r_tmo        = 32'(cpu_timeout);
                r_stall_resp = 32'(cpu_stall);
                break;
            end
        end
        cpu_req_valid = 1'b0;
        @(posedge clk); #1;
        r_done_after  = 32'(cpu_done);
        r_rdata_after = cpu_rdata;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_stall"}, 32'(cpu_stall), 0);
        check({tag, "_done"}, 32'(cpu_done), 0);
        check({tag, "_rdata"}, cpu_rdata, 0);
        check({tag, "_mis"}, 32'(cpu_misaligned), 0);
        check({tag, "_tmo"}, 32'(cpu_timeout), 0);
        check({tag, "_en"}, 32'(mem_enable), 0);
        check({tag, "_rw"}, 32'(mem_rw), 0);
    endtask

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t loads[$];

    initial begin
        int stalled;
        rst = 1'b1; hold = 1'b0;
        cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = 0;
        cpu_req_size = 0; cpu_req_unsigned = 0; cpu_req_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_addr", 32'(mem_addr), 0);
        check("reset_dout", mem_data_out, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Store word, then load it back with 3-cycle latency
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 10);
        check("sw_stall0", r_stall0, 1);
        check("sw_en", r_en, 1);
        check("sw_addr", r_addr, 4);
        check("sw_rw", r_rw, 4'b1111);
        check("sw_dout", r_dout, 32'hDEADBEEF);
        check("sw_lat", r_lat, 3);
        check("sw_rdata", r_rdata, 0);
        check("sw_stall_resp", r_stall_resp, 0);
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 10);
        check("lw_rw", r_rw, 0);
        check("lw_lat", r_lat, 3);
        check("lw_rdata", r_rdata, 32'hDEADBEEF);
        check("lw_done_after", r_done_after, 0);
        check("lw_rdata_after", r_rdata_after, 0);

        // Byte store to lane 3: word 4 becomes A5ADBEEF
        do_req(1'b1, 32'h13, 2'b00, 1'b0, 32'h123456A5, 10);
        check("sb_rw", r_rw, 4'b1000);
        check("sb_dout", r_dout, 32'hA5A5A5A5);
        check("sb_lat", r_lat, 3);

        // Word 5 = 80017FFF, then half store CAFE to upper lanes
        do_req(1'b1, 32'h14, 2'b10, 1'b0, 32'h80017FFF, 10);
        check("sw5_addr", r_addr, 5);

        loads.push_back('{"lb_s_13", 32'h13, 2'b00, 1'b0, 32'hFFFFFFA5});
        loads.push_back('{"lb_u_13", 32'h13, 2'b00, 1'b1, 32'h000000A5});
        loads.push_back('{"lb_s_10", 32'h10, 2'b00, 1'b0, 32'hFFFFFFEF});
        loads.push_back('{"lb_u_11", 32'h11, 2'b00, 1'b1, 32'h000000BE});
        loads.push_back('{"lb_s_12", 32'h12, 2'b00, 1'b0, 32'hFFFFFFAD});
        loads.push_back('{"lh_s_16", 32'h16, 2'b01, 1'b0, 32'hFFFF8001});
        loads.push_back('{"lh_s_14", 32'h14, 2'b01, 1'b0, 32'h00007FFF});
        loads.push_back('{"lh_u_16", 32'h16, 2'b01, 1'b1, 32'h00008001});
        loads.push_back('{"lh_s_12", 32'h12, 2'b01, 1'b0, 32'hFFFFA5AD});
        loads.push_back('{"lw_wrap", 32'hFFFFFC10, 2'b10, 1'b0, 32'hA5ADBEEF});
        foreach (loads[i]) begin
            do_req(1'b0, loads[i].addr, loads[i].size, loads[i].uns, 32'h0, 10);
            check({loads[i].tag, "_rdata"}, r_rdata, loads[i].exp);
            check({loads[i].tag, "_lat"}, r_lat, 3);
            check({loads[i].tag, "_mis"}, r_mis, 0);
        end
        check("lw_wrap_addr", r_addr, 4);

        do_req(1'b1, 32'h16, 2'b01, 1'b0, 32'h1234CAFE, 10);
        check("sh_rw", r_rw, 4'b1100);
        check("sh_dout", r_dout, 32'hCAFECAFE);
        do_req(1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 10);
        check("lw5_after_sh", r_rdata, 32'hCAFE7FFF);

        // Alignment and size errors: no RAM access, response one cycle later
        do_req(1'b0, 32'h02, 2'b10, 1'b0, 32'h0, 10);
        check("mis_w_en", r_en, 0);
        check("mis_w_lat", r_lat, 1);
        check("mis_w_flag", r_mis, 1);
        check("mis_w_rdata", r_rdata, 0);
        check("mis_w_after", r_done_after, 0);
        do_req(1'b0, 32'h00, 2'b11, 1'b0, 32'h0, 10);
        check("mis_sz_en", r_en, 0);
        check("mis_sz_lat", r_lat, 1);
        check("mis_sz_flag", r_mis, 1);
        do_req(1'b0, 32'h11, 2'b01, 1'b1, 32'h0, 10);
        check("mis_h_flag", r_mis, 1);
        check("mis_h_en", r_en, 0);
        do_req(1'b1, 32'h12, 2'b10, 1'b0, 32'hFFFFFFFF, 10);
        check("mis_sw_en", r_en, 0);
        check("mis_sw_flag", r_mis, 1);
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 10);
        check("mis_sw_nowrite", r_rdata, 32'hA5ADBEEF);

        // Reset during WAIT abandons the access
        hold = 1'b1;
        cpu_req_we = 0; cpu_req_addr = 32'h10; cpu_req_size = 2'b10;
        cpu_req_unsigned = 0; cpu_req_valid = 1'b1;
        @(posedge clk); #1;
        check("rstw_access_en", 32'(mem_enable), 1);
        @(posedge clk); #1;
        check("rstw_wait_stall", 32'(cpu_stall), 1);
        check("rstw_wait_en", 32'(mem_enable), 0);
        rst = 1'b1; cpu_req_valid = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("rstw");
        rst = 1'b0; hold = 1'b0;
        @(posedge clk); #1;
        check("rstw_no_done", 32'(cpu_done), 0);
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 10);
        check("rstw_next_lat", r_lat, 3);
        check("rstw_next_rdata", r_rdata, 32'hA5ADBEEF);

        // Store whose ACCESS cycle meets the reset edge still commits
        cpu_req_we = 1'b1; cpu_req_addr = 32'h20; cpu_req_size = 2'b10;
        cpu_req_wdata = 32'h11223344; cpu_req_valid = 1'b1;
        @(posedge clk); #1;
        check("rsta_access_en", 32'(mem_enable), 1);
        rst = 1'b1; cpu_req_valid = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("rsta");
        rst = 1'b0;
        @(posedge clk); #1;
        do_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 10);
        check("rsta_commit", r_rdata, 32'h11223344);

        // RAM never ready
        hold = 1'b1;
`ifdef ELBETH_LSU_TIMEOUT_EN
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 40);
        check("tmo_lat", r_lat, 18);
        check("tmo_flag", r_tmo, 1);
        check("tmo_rdata", r_rdata, 0);
        check("tmo_mis", r_mis, 0);
        check("tmo_after", r_done_after, 0);
        hold = 1'b0;
        @(posedge clk); #1;
`else
        cpu_req_we = 0; cpu_req_addr = 32'h10; cpu_req_size = 2'b10; cpu_req_valid = 1'b1;
        stalled = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (cpu_stall && !cpu_done && !cpu_timeout) stalled++;
        end
        check("hang_stalled", 32'(stalled), 40);
        hold = 1'b0;
        r_lat = 32'd999;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (cpu_done) begin
                r_lat   = c;
                r_rdata = cpu_rdata;
                break;
            end
        end
        cpu_req_valid = 1'b0;
        check("hang_release_lat", r_lat, 1);
        check("hang_release_rdata", r_rdata, 32'hA5ADBEEF);
        @(posedge clk); #1;
`endif

        check("no_spurious_rw", 32'(spur), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Overall watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
